// File: rtl/light_bar_pkg.sv
// light_bar_pkg: shared state encoding, mode-width helper and default timing constants for the light bar.
package light_bar_pkg;
    typedef enum logic [1:0] {OFF, GAP, RUN} state_t;
    localparam int DEBOUNCE_DEFAULT = 500000;
    localparam int GAP_DEFAULT = 16;
    function automatic int mode_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/light_bar_controller_if.sv
// light_bar_controller_if: enable/green/red bus between the controller and its pattern generators.
interface light_bar_controller_if #(parameter int NUM_PATTERNS = 4);
    logic [8*NUM_PATTERNS-1:0] pattern_green;
    logic [8*NUM_PATTERNS-1:0] pattern_red;
    logic [NUM_PATTERNS-1:0]   pattern_enable;
    modport master (output pattern_enable, input pattern_green, pattern_red);
    modport slave  (input pattern_enable, output pattern_green, pattern_red);
endinterface

// File: rtl/light_bar_controller_button_debounce.sv
// button_debounce: two-flop synchronizer, stability counter and one-cycle press pulse on accepted rising levels.
module button_debounce import light_bar_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], button};
            press <= 1'b0;
            if (sync[1] == stable) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= ~stable;
                cnt    <= '0;
                press  <= ~stable;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/light_bar_controller.sv
// light_bar_controller: debounced mode selection, break-before-make one-hot generator enable and light mux.
module light_bar_controller import light_bar_pkg::*; #(
    parameter int NUM_PATTERNS    = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int GAP_CYCLES      = GAP_DEFAULT,
    localparam int MODE_W         = mode_w(NUM_PATTERNS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  button,
    input  logic                  run_switch,
    light_bar_controller_if.master gen,
    output logic [7:0]            green_light,
    output logic [7:0]            red_light,
    output logic [MODE_W-1:0]     mode
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    state_t            state;
    logic [GW-1:0]     gap_cnt;
    logic              press;
    logic [MODE_W-1:0] mode_next;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk(clk), .rst_n(rst_n), .button(button), .press(press)
    );

    assign mode_next = (mode == MODE_W'(NUM_PATTERNS - 1)) ? '0 : mode + 1'b1;

    // Outputs default to dark each cycle; only a settled RUN cycle drives them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= OFF;
            mode               <= '0;
            gap_cnt            <= '0;
            gen.pattern_enable <= '0;
            green_light        <= '0;
            red_light          <= '0;
        end else begin
            if (press) mode <= mode_next;
            gen.pattern_enable <= '0;
            green_light        <= '0;
            red_light          <= '0;
            if (!run_switch) state <= OFF;
            else case (state)
                OFF: begin
                    state   <= GAP;
                    gap_cnt <= '0;
                end
                GAP: begin
                    if (press) gap_cnt <= '0;
                    else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state              <= RUN;
                        gen.pattern_enable <= NUM_PATTERNS'(1) << mode;
                    end else gap_cnt <= gap_cnt + 1'b1;
                end
                RUN: begin
                    if (press) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end else begin
                        gen.pattern_enable <= NUM_PATTERNS'(1) << mode;
                        green_light        <= gen.pattern_green[8*mode +: 8];
                        red_light          <= gen.pattern_red[8*mode +: 8];
                    end
                end
                default: state <= OFF;
            endcase
        end
    end
endmodule
